pc_gen_stage: RTL and testbench

- First pipeline stage. Generates the sequential instruction address stream and offers it to the fetch stage over a valid/ready pair.
- Applies branch redirects, honouring the MIPS delay slot, and exception/ERET redirects arriving from later stages.
- Output pair (valid_o, pc_o) connects directly to the fetch stage's valid_i/pc_i.
- ready_i is driven by the fetch stage's ready_o, which is its address-accepted strobe.

---
 rtl/pc_gen_stage.sv | 104 ++++++++++
 tb/tb_pc_gen_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_gen_stage: sequential PC generator with delay-slot branch and       |
// | exception redirects. Optional PC_ADEL_EN adds misaligned-fetch halt.   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module pc_gen_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   input  logic        br_valid,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_target,
   input  logic        exc_valid,
   input  logic [31:0] exc_target
`ifdef PC_ADEL_EN
   ,
   output logic        pc_adel_o
`endif
);

   localparam logic [31:0] c_step = 32'd4;

   logic [31:0] r_pc;
   logic        r_valid;
   logic        r_pend_v;
   logic [31:0] r_pend_tgt;

   logic [31:0] w_ds;
   logic [31:0] w_wp;
   logic        w_case_a;
   logic        w_case_b;
   logic        w_halted;
   logic        w_xfer;

   assign w_ds     = br_pc + c_step;
   assign w_wp     = br_pc + (c_step << 1);
   assign w_case_a = br_valid && (r_pc == w_ds);
   // Wrong-path address is on the bus right now: suppress it and redirect.
   assign w_case_b = br_valid && (r_pc == w_wp);

`ifdef PC_ADEL_EN
   logic r_halt;
   assign w_halted  = r_halt;
   assign pc_adel_o = valid_o && (r_pc[1:0] != 2'b00);
`else
   assign w_halted  = 1'b0;
`endif

   assign valid_o = r_valid && !exc_valid && !w_case_b && !w_halted;
   assign pc_o    = r_pc;
   assign w_xfer  = valid_o && ready_i;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_pc       <= RESET_PC;
         r_valid    <= 1'b0;
         r_pend_v   <= 1'b0;
         r_pend_tgt <= 32'd0;
      end else begin
         r_valid <= 1'b1;
         if (exc_valid) begin
            r_pc     <= exc_target;
            r_pend_v <= 1'b0;
         end else if (w_case_b) begin
            r_pc <= br_target;
         end else if (w_case_a) begin
            // Delay slot still on the bus: jump once it has been taken.
            if (w_xfer) begin
               r_pc <= br_target;
            end else begin
               r_pend_v   <= 1'b1;
               r_pend_tgt <= br_target;
            end
         end else if (w_xfer) begin
            if (r_pend_v) begin
               r_pc     <= r_pend_tgt;
               r_pend_v <= 1'b0;
            end else begin
               r_pc <= r_pc + c_step;
            end
         end
      end
   end

`ifdef PC_ADEL_EN
   // Sticky after a misaligned issue so only one AdEL reaches the pipeline.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_halt <= 1'b0;
      end else if (exc_valid) begin
         r_halt <= 1'b0;
      end else if (w_xfer && (r_pc[1:0] != 2'b00)) begin
         r_halt <= 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pc_gen_stage: directed + random checks of pc_gen_stage.             |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_pc_gen_stage;

   localparam logic [31:0] c_reset_pc = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        ready_i = 1'b0;
   logic        valid_o;
   logic [31:0] pc_o;
   logic        br_valid = 1'b0;
   logic [31:0] br_pc = 32'd0;
   logic [31:0] br_target = 32'd0;
   logic        exc_valid = 1'b0;
   logic [31:0] exc_target = 32'd0;
`ifdef PC_ADEL_EN
   logic        pc_adel_o;
`endif

   int tests = 0;
   int fails = 0;

   // Reference model: current address, started flag, pending redirect.
   logic [31:0] m_pc;
   bit          m_live;
   bit          m_pend;
   logic [31:0] m_tgt;
   bit          m_halt;

   always #5 clk = ~clk;

   pc_gen_stage #(.RESET_PC(c_reset_pc)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .ready_i    (ready_i),
      .valid_o    (valid_o),
      .pc_o       (pc_o),
      .br_valid   (br_valid),
      .br_pc      (br_pc),
      .br_target  (br_target),
      .exc_valid  (exc_valid),
      .exc_target (exc_target)
`ifdef PC_ADEL_EN
      ,
      .pc_adel_o  (pc_adel_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0; ready_i = 1'b0; br_valid = 1'b0; exc_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_pc", pc_o, c_reset_pc);
      m_pc = c_reset_pc; m_live = 0; m_pend = 0; m_halt = 0; m_tgt = 32'd0;
   endtask

   // One clock: drive inputs, compare outputs with the model, advance model.
   task automatic cycle(input bit rdy, input bit br, input logic [31:0] bpc,
                        input logic [31:0] btgt, input bit exc,
                        input logic [31:0] etgt, input string tag);
      bit exp_v;
      bit wrong_path;
      @(negedge clk);
      resetn = 1'b1; ready_i = rdy; br_valid = br; br_pc = bpc;
      br_target = btgt; exc_valid = exc; exc_target = etgt;
      #1;
      wrong_path = br && (m_pc == bpc + 32'd8);
      exp_v = m_live && !exc && !wrong_path && !m_halt;
      chk({tag, "_valid"}, {31'd0, valid_o}, {31'd0, exp_v});
      chk({tag, "_pc"}, pc_o, m_pc);
`ifdef PC_ADEL_EN
      chk({tag, "_adel"}, {31'd0, pc_adel_o}, {31'd0, exp_v && (m_pc % 4 != 0)});
`endif
      if (exc) begin
         m_pc = etgt; m_pend = 0; m_halt = 0;
      end else if (wrong_path) begin
         m_pc = btgt;
      end else begin
         if (br && m_pc == bpc + 32'd4) begin
            m_pend = 1; m_tgt = btgt;
         end
         if (exp_v && rdy) begin
`ifdef PC_ADEL_EN
            if (m_pc % 4 != 0) m_halt = 1;
`endif
            if (m_pend) begin
               m_pc = m_tgt; m_pend = 0;
            end else begin
               m_pc = m_pc + 32'd4;
            end
         end
      end
      m_live = 1;
   endtask

   initial begin
      bit          rdy, br, exc;
      logic [31:0] bpc, btgt, etgt;
      int          r;

      do_reset();
      cycle(1, 0, 0, 0, 0, 0, "rel");
      chk("rel_v0", {31'd0, valid_o}, 32'd0);
      cycle(1, 0, 0, 0, 0, 0, "s0");
      chk("s0_const", pc_o, 32'hBFC0_0000);
      cycle(1, 0, 0, 0, 0, 0, "s1");
      chk("s1_const", pc_o, 32'hBFC0_0004);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 0, 0, 0, "stall");
         chk("stall_const", pc_o, 32'hBFC0_0008);
      end
      cycle(1, 0, 0, 0, 0, 0, "s2");
      cycle(1, 0, 0, 0, 0, 0, "s3");
      chk("s3_const", pc_o, 32'hBFC0_000C);
      cycle(1, 0, 0, 0, 0, 0, "s4");

      // Branch whose delay slot is stalled on the bus.
      cycle(0, 1, 32'hBFC0_0010, 32'hBFC0_0100, 0, 0, "caseA");
      chk("caseA_const", pc_o, 32'hBFC0_0014);
      cycle(0, 0, 0, 0, 0, 0, "caseA_hold");
      cycle(1, 0, 0, 0, 0, 0, "caseA_ds");
      cycle(1, 0, 0, 0, 0, 0, "caseA_tgt");
      chk("caseA_tgt_const", pc_o, 32'hBFC0_0100);

      cycle(1, 0, 0, 0, 1, 32'hBFC0_0018, "exc_to18");
      chk("exc_to18_v", {31'd0, valid_o}, 32'd0);
      cycle(1, 1, 32'hBFC0_0010, 32'h8000_0000, 0, 0, "caseB");
      chk("caseB_v", {31'd0, valid_o}, 32'd0);
      cycle(1, 0, 0, 0, 0, 0, "caseB_tgt");
      chk("caseB_tgt_const", pc_o, 32'h8000_0000);

      // Exception must flush a pending redirect.
      cycle(0, 1, 32'h7FFF_FFFC, 32'h1234_5678, 0, 0, "pend");
      cycle(1, 0, 0, 0, 1, 32'hBFC0_0380, "exc");
      chk("exc_v", {31'd0, valid_o}, 32'd0);
      cycle(1, 0, 0, 0, 0, 0, "exc_tgt");
      chk("exc_tgt_const", pc_o, 32'hBFC0_0380);
      cycle(1, 0, 0, 0, 0, 0, "exc_next");
      chk("exc_next_const", pc_o, 32'hBFC0_0384);

      cycle(1, 0, 0, 0, 1, 32'hFFFF_FFFC, "wrap_exc");
      cycle(1, 0, 0, 0, 0, 0, "wrap_top");
      cycle(1, 0, 0, 0, 0, 0, "wrap_zero");
      chk("wrap_const", pc_o, 32'h0000_0000);

      // Reset drops a pending redirect.
      cycle(0, 1, 32'hFFFF_FFFC, 32'h0000_4000, 0, 0, "rst_pend");
      do_reset();
      cycle(1, 0, 0, 0, 0, 0, "rel2");
      cycle(1, 0, 0, 0, 0, 0, "rel2_a");
      cycle(1, 0, 0, 0, 0, 0, "rel2_b");
      chk("rel2_const", pc_o, 32'hBFC0_0004);

      for (int i = 0; i < 400; i++) begin
         rdy = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 19);
         exc = (r == 0);
         etgt = {$urandom(), 2'b00} >> 0;
         etgt[1:0] = 2'b00;
         br = 0; bpc = 0;
         btgt = $urandom();
         btgt[1:0] = 2'b00;
         if (!exc && r < 5 && !m_pend && m_live && !m_halt) begin
            br = 1;
            bpc = m_pc - (($urandom_range(0, 1) == 1) ? 32'd4 : 32'd8);
         end
         cycle(rdy, br, bpc, btgt, exc, etgt, "rnd");
      end

`ifdef PC_ADEL_EN
      cycle(1, 0, 0, 0, 1, 32'hBFC0_0382, "adel_exc");
      cycle(1, 0, 0, 0, 0, 0, "adel_issue");
      chk("adel_flag", {31'd0, pc_adel_o}, 32'd1);
      cycle(1, 0, 0, 0, 0, 0, "adel_halt0");
      chk("adel_halt0_v", {31'd0, valid_o}, 32'd0);
      cycle(1, 0, 0, 0, 0, 0, "adel_halt1");
      cycle(1, 0, 0, 0, 1, 32'hBFC0_0380, "adel_clr");
      cycle(1, 0, 0, 0, 0, 0, "adel_resume");
      chk("adel_resume_v", {31'd0, valid_o}, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
